// File: rtl/mem_data_skew_in.sv
// Input skew buffer for the systolic array: lane n of each captured word
// reaches the array n+1 enabled cycles later, with valid/last tags alongside.
module mem_data_skew_in #(
  parameter int DATA_WIDTH     = 8,
  parameter int ARRAY          = 32,
  parameter int MEM_DATA_WIDTH = DATA_WIDTH * ARRAY
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic                      valid_in,
  input  logic                      last_in,
  input  logic [MEM_DATA_WIDTH-1:0] data_in,
  output logic [MEM_DATA_WIDTH-1:0] data_out,
  output logic [ARRAY-1:0]          valid_out,
  output logic                      busy,
  output logic                      done
);

  // Flow control: a word is taken on every rising edge where enable=1 and
  // valid_in=1. There is no ready; enable=0 freezes every stage and ignores
  // valid_in, so the producer must hold off on its own while stalled.

  logic [ARRAY-1:0] lane_busy;
  logic [ARRAY-1:0] last_q;
  logic             done_q;

  genvar n;
  generate
    for (n = 0; n < ARRAY; n++) begin : g_lane
      logic [DATA_WIDTH-1:0] data_q [n+1];
      logic [n:0]            vld_q;

      // Invalid captures load zero so idle lanes read as zero downstream.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int k = 0; k <= n; k++) begin
            data_q[k] <= '0;
          end
          vld_q <= '0;
        end else if (enable) begin
          data_q[0] <= valid_in ? data_in[n*DATA_WIDTH +: DATA_WIDTH] : '0;
          vld_q[0]  <= valid_in;
          for (int k = 1; k <= n; k++) begin
            data_q[k] <= data_q[k-1];
            vld_q[k]  <= vld_q[k-1];
          end
        end
      end

      assign data_out[n*DATA_WIDTH +: DATA_WIDTH] = data_q[n];
      assign valid_out[n]                         = vld_q[n];
      assign lane_busy[n]                         = |vld_q;
    end
  endgenerate

  // The last tag only needs to follow the deepest lane, where the tile ends.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= '0;
    end else if (enable) begin
      last_q <= {last_q[ARRAY-2:0], valid_in & last_in};
    end
  end

  // done fires after the tagged word has been shifted out of lane ARRAY-1;
  // a stalled edge clears it, so a held tag waits for the next enabled edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_q <= 1'b0;
    end else begin
      done_q <= enable & last_q[ARRAY-1];
    end
  end

  assign done = done_q;
  assign busy = |lane_busy;

endmodule
